// File: rtl/ni_flit_injector.sv
// NI transmit side: packs core packets into wormhole flits for the router
// local port, choosing a VC round-robin and spending one credit per flit.
module ni_flit_injector #(
  parameter int V    = 4,
  parameter int B    = 4,
  parameter int Fpay = 32,
  parameter int NX   = 4,
  parameter int NY   = 4,
  parameter int Fw   = 2 + V + Fpay,
  parameter int Xw   = $clog2(NX),
  parameter int Yw   = $clog2(NY),
  parameter int CRw  = $clog2(B + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [Xw-1:0]   current_x,
  input  logic [Yw-1:0]   current_y,
  input  logic            pkt_valid,
  input  logic [Xw-1:0]   pkt_dest_x,
  input  logic [Yw-1:0]   pkt_dest_y,
  output logic            pkt_ready,
  input  logic            word_valid,
  input  logic [Fpay-1:0] word_data,
  input  logic            word_last,
  output logic            word_ready,
  output logic [Fw-1:0]   flit_out,
  output logic            flit_out_wr,
  input  logic [V-1:0]    credit_in,
  output logic            busy,
  output logic            credit_err
);

  localparam int VW = (V > 1) ? $clog2(V) : 1;
  localparam int HW = 2 * (Xw + Yw);

  typedef enum logic {
    IDLE,
    BODY
  } state_e;

  state_e          state_q, state_d;
  logic [CRw-1:0]  cnt_q [V];
  logic [CRw-1:0]  cnt_d [V];
  logic [VW-1:0]   rr_q, rr_d;
  logic [VW-1:0]   vc_q, vc_d;
  logic [Fw-1:0]   flit_q, flit_d;
  logic            wr_q, wr_d;
  logic            err_q, err_d;

  logic [VW-1:0]   sel;
  logic            sel_ok;
  logic [VW:0]     idx;
  logic [V-1:0]    sel_oh;
  logic [V-1:0]    vc_oh;
  logic [V-1:0]    send;
  logic [Fpay-1:0] head_pay;
  logic            vc_ok;

  // First VC with credit, scanning upward from the rr pointer
  always_comb begin
    sel    = '0;
    sel_ok = 1'b0;
    idx    = '0;
    for (int i = 0; i < V; i++) begin
      idx = {1'b0, rr_q} + (VW+1)'(i);
      if (idx >= (VW+1)'(V))
        idx = idx - (VW+1)'(V);
      if (!sel_ok && cnt_q[idx[VW-1:0]] != '0) begin
        sel    = idx[VW-1:0];
        sel_ok = 1'b1;
      end
    end
  end

  always_comb begin
    head_pay         = '0;
    head_pay[HW-1:0] = {pkt_dest_y, pkt_dest_x,
                        current_y, current_x};
  end

  assign sel_oh = V'(1) << sel;
  assign vc_oh  = V'(1) << vc_q;
  assign vc_ok  = cnt_q[vc_q] != '0;

  assign pkt_ready  = !reset && state_q == IDLE
                    && pkt_valid && sel_ok;
  assign word_ready = !reset && state_q == BODY
                    && word_valid && vc_ok;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    vc_d    = vc_q;
    flit_d  = flit_q;
    wr_d    = 1'b0;
    send    = '0;
    case (state_q)
      IDLE: begin
        if (pkt_ready) begin
          send    = sel_oh;
          flit_d  = {1'b1, 1'b0, sel_oh, head_pay};
          wr_d    = 1'b1;
          vc_d    = sel;
          rr_d    = (sel == VW'(V - 1)) ? '0 : sel + 1'b1;
          state_d = BODY;
        end
      end
      BODY: begin
        if (word_ready) begin
          send   = vc_oh;
          flit_d = {1'b0, word_last, vc_oh, word_data};
          wr_d   = 1'b1;
          if (word_last)
            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A return into a full counter is a router protocol error
  always_comb begin
    err_d = err_q;
    for (int v = 0; v < V; v++) begin
      cnt_d[v] = cnt_q[v];
      if (credit_in[v] && !send[v]) begin
        if (cnt_q[v] == CRw'(B))
          err_d = 1'b1;
        else
          cnt_d[v] = cnt_q[v] + CRw'(1);
      end else if (!credit_in[v] && send[v]) begin
        cnt_d[v] = cnt_q[v] - CRw'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      vc_q    <= '0;
      flit_q  <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      for (int v = 0; v < V; v++)
        cnt_q[v] <= CRw'(B);
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      vc_q    <= vc_d;
      flit_q  <= flit_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      for (int v = 0; v < V; v++)
        cnt_q[v] <= cnt_d[v];
    end
  end

  assign flit_out    = flit_q;
  assign flit_out_wr = wr_q;
  assign busy        = state_q != IDLE;
  assign credit_err  = err_q;

endmodule
